// File: rtl/adder_accum_sequencer_if.sv
// adder_accum_sequencer_if: host-side command/response handshake for the accumulator sequencer
interface adder_accum_sequencer_if #(
    parameter int WIDTH = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [WIDTH-1:0]   cmd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [3*WIDTH-1:0] rsp_data;
    modport master (output cmd_valid, cmd_op, cmd_data, rsp_ready, input cmd_ready, rsp_valid, rsp_data);
    modport slave  (input cmd_valid, cmd_op, cmd_data, rsp_ready, output cmd_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/adder_accum_sequencer.sv
// adder_accum_sequencer: turns host ADD/READ/CLEAR commands into AdderAccumulator control sequences
module adder_accum_sequencer #(
    parameter int               WIDTH   = 8,
    parameter int               SEL_W   = 3,
    parameter logic [SEL_W-1:0] SEL_LSB = SEL_W'(0),
    parameter logic [SEL_W-1:0] SEL_MSB = SEL_W'(1),
    parameter logic [SEL_W-1:0] SEL_CNT = SEL_W'(2),
    parameter int               SETTLE  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    adder_accum_sequencer_if.slave host,
    output logic                  acc_load,
    output logic                  acc_add,
    output logic                  acc_reset,
    output logic [WIDTH-1:0]      acc_data_in,
    output logic [SEL_W-1:0]      acc_output_sel,
    input  logic [WIDTH-1:0]      acc_data_out,
    output logic                  busy
);
    localparam int CW = $clog2(SETTLE + 2);

    typedef enum logic [2:0] {IDLE, LOAD, ADD, CLR, RD_LSB, RD_MSB, RD_CNT, RSP} state_t;

    state_t        state;
    logic [CW-1:0] settle_cnt;
    logic          clr_q;
    logic          settled;
    logic          reading;

    assign settled        = settle_cnt == CW'(SETTLE);
    assign reading        = state == RD_LSB || state == RD_MSB || state == RD_CNT;
    assign acc_reset      = clr_q | ~reset;
    assign host.cmd_ready = state == IDLE;
    assign busy           = state != IDLE;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            clr_q          <= 1'b0;
            acc_load       <= 1'b0;
            acc_add        <= 1'b0;
            acc_data_in    <= '0;
            acc_output_sel <= SEL_LSB;
            host.rsp_valid <= 1'b0;
            host.rsp_data  <= '0;
        end else begin
            settle_cnt <= (reading && !settled) ? settle_cnt + CW'(1) : '0;
            case (state)
                IDLE: if (host.cmd_valid) begin
                    case (host.cmd_op)
                        2'b00: begin
                            state       <= LOAD;
                            acc_load    <= 1'b1;
                            acc_data_in <= host.cmd_data;
                        end
                        2'b01: state <= RD_LSB;
                        2'b10: begin
                            state <= CLR;
                            clr_q <= 1'b1;
                        end
                        default: state <= IDLE;
                    endcase
                end
                // all-ones operand during ADD makes any stray register-1 capture visible
                LOAD: begin
                    state       <= ADD;
                    acc_load    <= 1'b0;
                    acc_add     <= 1'b1;
                    acc_data_in <= '1;
                end
                ADD: begin
                    state   <= IDLE;
                    acc_add <= 1'b0;
                end
                CLR: begin
                    state <= IDLE;
                    clr_q <= 1'b0;
                end
                RD_LSB: if (settled) begin
                    host.rsp_data[WIDTH-1:0] <= acc_data_out;
                    acc_output_sel           <= SEL_MSB;
                    state                    <= RD_MSB;
                end
                RD_MSB: if (settled) begin
                    host.rsp_data[2*WIDTH-1:WIDTH] <= acc_data_out;
                    acc_output_sel                 <= SEL_CNT;
                    state                          <= RD_CNT;
                end
                RD_CNT: if (settled) begin
                    host.rsp_data[3*WIDTH-1:2*WIDTH] <= acc_data_out;
                    acc_output_sel                   <= SEL_LSB;
                    host.rsp_valid                   <= 1'b1;
                    state                            <= RSP;
                end
                RSP: if (host.rsp_ready) begin
                    host.rsp_valid <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_accum_sequencer.sv
// tb_adder_accum_sequencer: directed checks of the sequencer against a behavioural AdderAccumulator
module tb_adder_accum_sequencer;
    logic       clock = 1'b0;
    logic       reset;
    logic       acc_load, acc_add, acc_reset;
    logic [7:0] acc_data_in, acc_data_out;
    logic [2:0] acc_output_sel;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_load = 0;
    int n_add = 0;
    int n_ovl = 0;

    logic [15:0] m_acc;
    logic [7:0]  m_reg, m_cnt;

    adder_accum_sequencer_if #(.WIDTH(8)) h ();

    adder_accum_sequencer #(.WIDTH(8), .SETTLE(1)) dut (
        .clock(clock), .reset(reset), .host(h),
        .acc_load(acc_load), .acc_add(acc_add), .acc_reset(acc_reset),
        .acc_data_in(acc_data_in), .acc_output_sel(acc_output_sel),
        .acc_data_out(acc_data_out), .busy(busy)
    );

    always #5 clock = ~clock;

    // accumulator peer: 16-bit sum, counter counts carries out of bit 7
    always @(posedge clock) begin
        if (acc_reset) begin
            m_acc <= '0;
            m_reg <= '0;
            m_cnt <= '0;
        end else if (acc_load) begin
            m_reg <= acc_data_in;
        end else if (acc_add) begin
            m_acc <= m_acc + {8'h00, m_reg};
            if ({1'b0, m_acc[7:0]} + {1'b0, m_reg} > 9'd255) m_cnt <= m_cnt + 8'd1;
        end
    end

    assign acc_data_out = acc_output_sel == 3'd0 ? m_acc[7:0] :
                          acc_output_sel == 3'd1 ? m_acc[15:8] :
                          acc_output_sel == 3'd2 ? m_cnt : 8'h00;

    always @(posedge clock) begin
        if (acc_load) n_load++;
        if (acc_add) n_add++;
        if (acc_load && acc_add) n_ovl++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] d);
        int  n = 0;
        logic taken;
        h.cmd_valid = 1'b1;
        h.cmd_op    = op;
        h.cmd_data  = d;
        do begin
            taken = h.cmd_ready;
            tick();
            n++;
        end while (!taken && n < 50);
        if (!taken) check("accept_timeout", 0, 1);
        h.cmd_valid = 1'b0;
    endtask

    task automatic do_read(output logic [23:0] r, output int lat);
        int n = 0;
        send(2'b01, 8'h00);
        while (!h.rsp_valid && n < 40) begin
            tick();
            n++;
        end
        lat = n;
        if (!h.rsp_valid) check("rsp_timeout", 0, 1);
        r = h.rsp_data;
        if (h.rsp_ready) tick();
    endtask

    initial begin
        logic [23:0] r, r0;
        int lat, bad;
        reset = 1'b0;
        h.cmd_valid = 1'b0;
        h.cmd_op = 2'b11;
        h.cmd_data = 8'h00;
        h.rsp_ready = 1'b1;
        tick();
        check("rst_acc_reset", acc_reset, 1);
        check("rst_outputs", {acc_load, acc_add, busy, h.rsp_valid, acc_data_in, acc_output_sel}, 0);
        tick();
        reset = 1'b1;
        n_load = 0;
        n_add = 0;
        check("rst_ready_first", h.cmd_ready, 1);
        repeat (5) tick();
        check("idle_state", {h.cmd_ready, acc_output_sel, h.rsp_valid, acc_reset}, {1'b1, 3'd0, 1'b0, 1'b0});
        check("idle_pulses", n_load + n_add, 0);

        // CLEAR timing, then two ADDs with cycle-accurate pulse checks
        send(2'b10, 8'h00);
        check("clr_pulse", acc_reset, 1);
        tick();
        check("clr_done", {acc_reset, h.cmd_ready}, 2'b01);
        n_load = 0;
        n_add = 0;
        n_ovl = 0;
        send(2'b00, 8'h42);
        check("add_load", {acc_load, acc_add, acc_data_in}, {2'b10, 8'h42});
        tick();
        check("add_add", {acc_load, acc_add, acc_data_in, h.cmd_ready}, {2'b01, 8'hFF, 1'b0});
        tick();
        check("add_ready", {h.cmd_ready, acc_add}, 2'b10);
        send(2'b00, 8'hEE);
        do_read(r, lat);
        check("read_latency", lat, 6);
        check("read_0x130", r, 24'h01_01_30);
        check("pulse_counts", {n_load[7:0], n_add[7:0], n_ovl[7:0]}, {8'd2, 8'd2, 8'd0});

        // 300 * 0xFE = 0x129A8; 297 carries out of bit 7 -> cnt 0x29
        send(2'b10, 8'h00);
        repeat (300) send(2'b00, 8'hFE);
        do_read(r, lat);
        check("read_300_lsb", r[7:0], 8'hA8);
        check("read_300_msb", r[15:8], 8'h29);
        check("read_300_cnt", r[23:16], 8'h29);

        // backpressure: response held, pending ADD must wait for handshake
        h.rsp_ready = 1'b0;
        do_read(r0, lat);
        check("bp_rsp", r0, 24'h29_29_A8);
        h.cmd_valid = 1'b1;
        h.cmd_op = 2'b00;
        h.cmd_data = 8'h01;
        n_load = 0;
        bad = 0;
        repeat (10) begin
            tick();
            if (h.cmd_ready || !h.rsp_valid || h.rsp_data !== r0) bad++;
        end
        check("bp_hold", bad, 0);
        check("bp_no_load", n_load, 0);
        h.rsp_ready = 1'b1;
        tick();
        check("bp_released", {h.rsp_valid, h.cmd_ready}, 2'b01);
        tick();
        check("bp_add_taken", {acc_load, acc_data_in}, {1'b1, 8'h01});
        h.cmd_valid = 1'b0;
        repeat (3) tick();

        // reset mid-READ while in RD_MSB
        send(2'b01, 8'h00);
        tick();
        tick();
        check("in_rd_msb", {acc_output_sel, busy}, {3'd1, 1'b1});
        #2;
        reset = 1'b0;
        #1;
        check("abort_outputs", {acc_reset, busy, h.cmd_ready, acc_output_sel, h.rsp_valid}, {3'b101, 3'd0, 1'b0});
        check("abort_rsp_data", h.rsp_data, 0);
        tick();
        reset = 1'b1;
        bad = 0;
        repeat (10) begin
            tick();
            if (h.rsp_valid) bad++;
        end
        check("abort_no_rsp", bad, 0);
        send(2'b10, 8'h00);
        do_read(r, lat);
        check("read_after_abort", r, 24'h0);

        // NOP stream: accepted every cycle, never busy, no accumulator activity
        n_load = 0;
        n_add = 0;
        h.cmd_valid = 1'b1;
        h.cmd_op = 2'b11;
        bad = 0;
        repeat (6) begin
            tick();
            if (!h.cmd_ready || busy || acc_reset) bad++;
        end
        h.cmd_valid = 1'b0;
        check("nop_stream", bad, 0);
        check("nop_pulses", n_load + n_add, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
